ft2232_fifo_host: RTL and testbench

FPGA-side controller for the FT2232H synchronous 245 FIFO interface, the counterpart of the FT2232 chip. It turns the chip's FIFO pins into two byte streams with valid/ready handshakes:

- **RX** carries bytes from host to FPGA. It is drained by the test/command logic.
- **TX** carries bytes from FPGA to host.

It owns bus direction, OE#/RD#/WR# sequencing and RX/TX arbitration, and sits between the top-level TRELLIS_IO pad ring and the command engine.

---
 rtl/ft2232_fifo_host_pkg.sv | 35 +++
 rtl/ft2232_fifo_host_sync_fifo.sv | 53 +++++
 rtl/ft2232_fifo_host.sv | 128 ++++++++++++
 tb/tb_ft2232_fifo_host.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft2232_fifo_host_pkg.sv
// Shared constants and strobe decode for the FT2232H synchronous 245 FIFO host.
package ft2232_fifo_host_pkg;

  localparam int FT_FIFO_DEPTH_DEF = 8;
  localparam int FT_BURST_MAX_DEF  = 64;

  localparam logic [2:0] FT_STATE_IDLE  = 3'd0;
  localparam logic [2:0] FT_STATE_RD_OE = 3'd1;
  localparam logic [2:0] FT_STATE_RD    = 3'd2;
  localparam logic [2:0] FT_STATE_TURN  = 3'd3;
  localparam logic [2:0] FT_STATE_WR    = 3'd4;

  localparam logic FT_DIR_RX = 1'b0;
  localparam logic FT_DIR_TX = 1'b1;

  typedef struct packed {
    logic oe_n;
    logic rd_n;
    logic wr_n;
    logic data_t;
  } ft_strobe_t;

  // Strobes depend only on registered state and FIFO flags, so they are glitch-free
  // relative to the chip's sampling edge.
  function automatic ft_strobe_t ft_strobes(input logic [2:0] st, input logic rx_full,
                                            input logic tx_empty);
    ft_strobe_t s;
    s.oe_n   = !((st == FT_STATE_RD_OE) || (st == FT_STATE_RD));
    s.rd_n   = !((st == FT_STATE_RD) && !rx_full);
    s.wr_n   = !((st == FT_STATE_WR) && !tx_empty);
    s.data_t = (st != FT_STATE_WR);
    return s;
  endfunction

endpackage

// File: rtl/ft2232_fifo_host_sync_fifo.sv
// Single-clock skid FIFO: registered count, full/empty flags, head visible combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             push_ok, pop_ok;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; simultaneous push/pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ft2232_fifo_host.sv
// FT2232H sync-245 FIFO controller: bus direction, OE#/RD#/WR# sequencing and
// RX/TX burst arbitration between two byte streams. The bidirectional pad lives
// in the pad ring and is driven through fifo_data_o / fifo_data_t_o.
module ft2232_fifo_host
  import ft2232_fifo_host_pkg::*;
#(
  parameter int FIFO_DEPTH = FT_FIFO_DEPTH_DEF,
  parameter int BURST_MAX  = FT_BURST_MAX_DEF
) (
  input  logic       fifo_clk_i,
  input  logic       reset_n_i,
  input  logic       fifo_txe_n_i,
  input  logic       fifo_rxf_n_i,
  output logic       fifo_oe_n_o,
  output logic       fifo_rd_n_o,
  output logic       fifo_wr_n_o,
  output logic       fifo_siwu_o,
  input  logic [7:0] fifo_data_i,
  output logic [7:0] fifo_data_o,
  output logic       fifo_data_t_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o
);
  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

  logic [2:0] state, state_nxt;
  logic [7:0] burst_cnt, burst_nxt, burst_inc;
  logic       last_dir, dir_nxt;

  logic       rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, tx_push, tx_pop;
  logic       rx_req, tx_req;
  ft_strobe_t strb;

  assign strb = ft_strobes(state, rx_full, tx_empty);

  // A transfer on the chip side happens only when our strobe and the chip's flag are both low.
  assign rx_push   = !strb.rd_n && !fifo_rxf_n_i;
  assign tx_pop    = !strb.wr_n && !fifo_txe_n_i;
  assign rx_pop    = !rx_empty && rx_ready_i;
  assign tx_push   = tx_valid_i && !tx_full;
  assign rx_req    = !fifo_rxf_n_i && !rx_full;
  assign tx_req    = !fifo_txe_n_i && !tx_empty;
  assign burst_inc = burst_cnt + 8'd1;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rx_q (
    .clk   (fifo_clk_i),
    .rst_n (reset_n_i),
    .push  (rx_push),
    .wdata (fifo_data_i),
    .pop   (rx_pop),
    .rdata (rx_data_o),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) tx_q (
    .clk   (fifo_clk_i),
    .rst_n (reset_n_i),
    .push  (tx_push),
    .wdata (tx_data_i),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Next-state, burst count and direction memory for round-robin arbitration.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    dir_nxt   = last_dir;
    case (state)
      FT_STATE_IDLE: begin
        burst_nxt = '0;
        if (rx_req && (!tx_req || last_dir == FT_DIR_TX)) begin
          state_nxt = FT_STATE_RD_OE;
          dir_nxt   = FT_DIR_RX;
        end else if (tx_req) begin
          state_nxt = FT_STATE_WR;
          dir_nxt   = FT_DIR_TX;
        end
      end
      FT_STATE_RD_OE: state_nxt = FT_STATE_RD;
      FT_STATE_RD: begin
        if (rx_push) burst_nxt = burst_inc;
        // Leave on the capture that hits the limit so no extra byte is strobed.
        if (fifo_rxf_n_i || rx_full || (rx_push && burst_inc == BURST_LIM))
          state_nxt = FT_STATE_TURN;
      end
      FT_STATE_TURN: state_nxt = FT_STATE_IDLE;
      FT_STATE_WR: begin
        if (tx_pop) burst_nxt = burst_inc;
        if (fifo_txe_n_i || tx_empty || (tx_pop && burst_inc == BURST_LIM))
          state_nxt = FT_STATE_IDLE;
      end
      default: state_nxt = FT_STATE_IDLE;
    endcase
  end

  // Control registers; last_dir resets to TX so RX wins the first contested round.
  always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= FT_STATE_IDLE;
      burst_cnt <= '0;
      last_dir  <= FT_DIR_TX;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      last_dir  <= dir_nxt;
    end
  end

  assign fifo_oe_n_o   = strb.oe_n;
  assign fifo_rd_n_o   = strb.rd_n;
  assign fifo_wr_n_o   = strb.wr_n;
  assign fifo_data_t_o = strb.data_t;
  assign fifo_siwu_o   = 1'b1;
  assign fifo_data_o   = tx_empty ? 8'h00 : tx_head;
  assign rx_valid_o    = !rx_empty;
  assign tx_ready_o    = !tx_full;

endmodule

// File: tb/tb_ft2232_fifo_host.sv
// Directed bench for ft2232_fifo_host with a small behavioural FT2232 chip model.
module tb_ft2232_fifo_host;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       txe_n, rxf_n, oe_n, rd_n, wr_n, siwu;
  logic [7:0] din, dout;
  logic       data_t;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;

  always #5 clk = ~clk;

  ft2232_fifo_host #(.FIFO_DEPTH(8), .BURST_MAX(4)) dut (
    .fifo_clk_i    (clk),
    .reset_n_i     (rst_n),
    .fifo_txe_n_i  (txe_n),
    .fifo_rxf_n_i  (rxf_n),
    .fifo_oe_n_o   (oe_n),
    .fifo_rd_n_o   (rd_n),
    .fifo_wr_n_o   (wr_n),
    .fifo_siwu_o   (siwu),
    .fifo_data_i   (din),
    .fifo_data_o   (dout),
    .fifo_data_t_o (data_t),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Chip-model state. Queues are edited by the chip at posedge+1, by the test at negedge.
  logic [7:0] host_q[$];
  logic [7:0] chip_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         dir_q[$];
  bit         rx_en = 1'b1;
  bit         txe_block = 1'b0;
  bit         stall_arm = 1'b0;
  int         rfire_cnt = 0;
  int         oe_rd_err = 0;
  int         bus_err = 0;

  // FT2232 model plus protocol monitors: sample strobes at negedge, act just after posedge.
  initial begin : chip
    logic rf, wf, cf;
    logic [7:0] wd, cd;
    logic oe_p1, oe_p2, rd_p1, dt_p1;
    int oe_hi;
    rxf_n = 1'b1; txe_n = 1'b0; din = 8'h00;
    oe_p1 = 1'b1; oe_p2 = 1'b1; rd_p1 = 1'b1; dt_p1 = 1'b1; oe_hi = 100;
    forever begin
      @(negedge clk);
      if (stall_arm && !wr_n && dout == 8'h12) begin
        txe_n = 1'b1;
        stall_arm = 1'b0;
      end
      rf = !rd_n && !rxf_n;
      wf = !wr_n && !txe_n;
      wd = dout;
      cf = rx_valid && rx_ready;
      cd = rx_data;
      if (!oe_n && !data_t) bus_err++;
      if (rd_p1 && !rd_n && !(!oe_p1 && oe_p2)) oe_rd_err++;
      if (dt_p1 && !data_t && oe_hi < 2) bus_err++;
      oe_hi = oe_n ? oe_hi + 1 : 0;
      oe_p2 = oe_p1; oe_p1 = oe_n; rd_p1 = rd_n; dt_p1 = data_t;
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (rf && host_q.size() > 0) begin
          void'(host_q.pop_front());
          rfire_cnt++;
          dir_q.push_back(1'b0);
        end
        if (wf) begin
          chip_q.push_back(wd);
          dir_q.push_back(1'b1);
        end
        if (cf) got_q.push_back(cd);
      end
      rxf_n = !(rx_en && host_q.size() > 0);
      din   = (host_q.size() > 0) ? host_q[0] : 8'h00;
      txe_n = txe_block;
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic send_tx(input logic [7:0] b);
    int t;
    t = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("tx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (got_q.size() < n && t < budget) begin
      t++;
      @(negedge clk);
    end
    if (got_q.size() < n) chk("rx_timeout", got_q.size(), n);
  endtask

  initial begin : main
    int n;
    int base;
    logic [15:0] seq;
    rst_n = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_oe_n", oe_n, 1'b1);
    chk("rst_rd_n", rd_n, 1'b1);
    chk("rst_wr_n", wr_n, 1'b1);
    chk("rst_data_t", data_t, 1'b1);
    chk("rst_data_o", dout, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("siwu", siwu, 1'b1);
    sync();
    rst_n = 1'b1;
    repeat (3) sync();

    // RX latency: byte visible after the 3rd edge out of IDLE
    @(negedge clk);
    host_q.push_back(8'hA5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_valid && n < 20);
    chk("rx_latency", n, 4);
    chk("rx_first_byte", rx_data, 8'hA5);
    sync();
    rx_ready = 1'b1;
    wait_rx(1, 20);
    repeat (4) sync();

    // Host->FPGA stream of 67 bytes
    @(negedge clk);
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h02);
    for (int i = 0; i < 63; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h03);
    foreach (exp_q[i]) host_q.push_back(exp_q[i]);
    wait_rx(67, 2000);
    repeat (10) @(negedge clk);
    chk("stream_count", got_q.size(), 67);
    for (int i = 0; i < 67 && i < got_q.size(); i++) chk("stream_byte", got_q[i], exp_q[i]);

    // RX backpressure: only FIFO_DEPTH bytes captured
    sync();
    rx_ready = 1'b0;
    @(negedge clk);
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'h40 + 8'(i));
      host_q.push_back(8'h40 + 8'(i));
    end
    repeat (60) @(negedge clk);
    chk("bp_left_in_chip", host_q.size(), 12);
    chk("bp_rd_n_high", rd_n, 1'b1);
    chk("bp_rx_valid", rx_valid, 1'b1);
    sync();
    rx_ready = 1'b1;
    wait_rx(20, 500);
    repeat (10) @(negedge clk);
    chk("bp_count", got_q.size(), 20);
    for (int i = 0; i < 20 && i < got_q.size(); i++) chk("bp_byte", got_q[i], exp_q[i]);

    // TX latency: accepted at E, chip takes it at E+2
    @(negedge clk);
    chip_q.delete();
    sync();
    send_tx(8'h5A);
    n = 0;
    do begin
      sync();
      n++;
    end while (chip_q.size() == 0 && n < 20);
    chk("tx_latency", n, 2);
    chk("tx_first_byte", (chip_q.size() > 0) ? chip_q[0] : 8'hXX, 8'h5A);
    repeat (4) sync();

    // TX with a TXE# stall on the 0x12 cycle
    @(negedge clk);
    chip_q.delete();
    sync();
    stall_arm = 1'b1;
    for (int i = 0; i < 5; i++) send_tx(8'h10 + 8'(i));
    repeat (30) @(negedge clk);
    chk("stall_hit", stall_arm, 1'b0);
    chk("stall_count", chip_q.size(), 5);
    for (int i = 0; i < 5 && i < chip_q.size(); i++) chk("stall_byte", chip_q[i], 8'h10 + 8'(i));

    // Arbitration: both sides loaded, bursts of 4 alternate starting with RX
    sync();
    txe_block = 1'b1;
    rx_en = 1'b0;
    repeat (2) sync();
    for (int i = 0; i < 8; i++) send_tx(8'h80 + 8'(i));
    @(negedge clk);
    for (int i = 0; i < 8; i++) host_q.push_back(8'hC0 + 8'(i));
    dir_q.delete();
    chip_q.delete();
    got_q.delete();
    sync();
    rx_en = 1'b1;
    txe_block = 1'b0;
    repeat (100) @(negedge clk);
    seq = '0;
    foreach (dir_q[i]) seq = {seq[14:0], dir_q[i]};
    chk("arb_transfers", dir_q.size(), 16);
    chk("arb_sequence", seq, 16'h0F0F);
    chk("arb_rx_count", got_q.size(), 8);
    chk("arb_tx_count", chip_q.size(), 8);
    chk("arb_tx_last", (chip_q.size() == 8) ? chip_q[7] : 8'hXX, 8'h87);

    // Reset in the middle of an RX burst with 3 bytes queued
    sync();
    rx_ready = 1'b0;
    @(negedge clk);
    base = rfire_cnt;
    for (int i = 0; i < 20; i++) host_q.push_back(8'h60 + 8'(i));
    n = 0;
    while (rfire_cnt < base + 3 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mid_burst_reached", rd_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_n", rd_n, 1'b1);
    chk("mid_rst_oe_n", oe_n, 1'b1);
    chk("mid_rst_wr_n", wr_n, 1'b1);
    chk("mid_rst_rx_valid", rx_valid, 1'b0);
    chk("mid_rst_tx_ready", tx_ready, 1'b1);
    repeat (2) sync();
    @(negedge clk);
    host_q.delete();
    got_q.delete();
    sync();
    rst_n = 1'b1;
    rx_ready = 1'b1;
    repeat (2) sync();
    @(negedge clk);
    host_q.push_back(8'h11);
    host_q.push_back(8'h22);
    wait_rx(2, 100);
    repeat (10) @(negedge clk);
    chk("post_rst_count", got_q.size(), 2);
    chk("post_rst_b0", (got_q.size() > 0) ? got_q[0] : 8'hXX, 8'h11);
    chk("post_rst_b1", (got_q.size() > 1) ? got_q[1] : 8'hXX, 8'h22);

    // Protocol monitors accumulated over the whole run
    chk("oe_leads_rd", oe_rd_err, 0);
    chk("bus_turnaround", bus_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
